// File: rtl/p12_eni_ctrl_if.sv
// Register-bus interface for the P12 input-enable sequencer: one write port plus a combinational read-back.
interface p12_eni_ctrl_if;
    logic       wr;
    logic       addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output wr, output addr, output wdata, input rdata);
    modport slave  (input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/p12_eni_ctrl.sv
// P12 input-enable sequencer: walks eni toward TARGET one bit at a time with a settle gap after each change.
// Optional build macro P12_ENI_LOCK_EN adds a sticky CTRL lock bit that freezes TARGET writes.
module p12_eni_ctrl #(
    parameter int WIDTH      = 3,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              resetb,
    p12_eni_ctrl_if.slave     bus,
    output logic [WIDTH-1:0]  eni,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, STEP, SETTLE} state_e;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] eni_q, eni_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             lock;
    logic [WIDTH-1:0] diff;
    logic             tgt_wr;

`ifdef P12_ENI_LOCK_EN
    logic lock_q, lock_d;

    assign lock_d = lock_q | (bus.wr & bus.addr & bus.wdata[0]);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) lock_q <= 1'b0;
        else         lock_q <= lock_d;
    end

    assign lock = lock_q;
`else
    assign lock = 1'b0;
`endif

    // Lock is sampled pre-edge, so the write that sets it cannot itself be blocked.
    assign tgt_wr = bus.wr & ~bus.addr & ~lock;
    assign tgt_d  = tgt_wr ? bus.wdata[WIDTH-1:0] : tgt_q;
    assign diff   = eni_q ^ tgt_q;

    // NOTE: always_comb uses blocking assignments with every output defaulted first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        eni_d   = eni_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (diff != '0) state_d = STEP;
            end
            STEP: begin
                // diff & -diff isolates the lowest differing bit.
                eni_d   = eni_q ^ (diff & (~diff + WIDTH'(1)));
                cnt_d   = SETTLE_LOAD;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (diff != '0) begin
                    state_d = STEP;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; every register has an explicit async reset value.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
            eni_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            eni_q   <= eni_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign eni  = eni_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

    always_comb begin
        logic [7:0] tgt_ext;
        logic [2:0] eni_ext;
        tgt_ext               = '0;
        tgt_ext[WIDTH-1:0]    = tgt_q;
        eni_ext               = '0;
        eni_ext[WIDTH-1:0]    = eni_q;
        bus.rdata = bus.addr ? {3'b000, busy, lock, eni_ext} : tgt_ext;
    end

endmodule

// File: doc/p12_eni_ctrl.md
P12_ENI_CTRL -- requirements
Module: p12_eni_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 3, number of P12 input-enable bits (legal 1..3).
REQ-002 SHALL have parameter SETTLE_CYC, default 4, settle cycles after each enable-bit change (legal 1..255).
REQ-003 SHALL have port clk  input  1  single block clock; all state updates on its rising edge.
REQ-004 SHALL have port resetb  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port wr  input  1  register write strobe, one write per high cycle.
REQ-006 SHALL have port addr  input  1  register select: 0 = TARGET, 1 = CTRL.
REQ-007 SHALL have port wdata  input  8  write data.
REQ-008 SHALL have port rdata  output  8  combinational read of the register selected by addr.
REQ-009 SHALL have port eni  output  WIDTH  registered input-enable bus to P12_IOBUF.
REQ-010 SHALL have port busy  output  1  high while the sequencer is outside IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when eni reaches TARGET.

Function
REQ-012 SHALL hold a TARGET register tgt[WIDTH-1:0].
- A write with wr=1 and addr=0 loads tgt from wdata[WIDTH-1:0] at that edge.
- Writes are accepted while busy.
REQ-013 SHALL return rdata as follows:
- addr=0: tgt, zero-extended.
- addr=1: {3'b0, busy, lock, eni zero-extended to 3 bits}.
REQ-014 SHALL run an FSM with states IDLE, STEP and SETTLE.
REQ-015 IDLE SHALL move to STEP on the next edge when eni != tgt; otherwise it SHALL remain in IDLE.
REQ-016 STEP SHALL take one cycle, then:
- toggle only the lowest-index eni bit that differs from tgt;
- load the settle counter with SETTLE_CYC-1;
- enter SETTLE.
REQ-017 SETTLE SHALL decrement the counter each cycle. At count 0:
- if eni != tgt (current tgt), go to STEP;
- else go to IDLE and assert done for exactly the one following cycle.
REQ-018 A TARGET write during STEP or SETTLE SHALL NOT abort the settle; the new tgt SHALL be evaluated at the SETTLE exit.
- If the new tgt equals eni at that point, the FSM returns to IDLE and pulses done.
REQ-019 eni SHALL never change more than one bit per edge.
- At most one bit change per STEP+SETTLE period of SETTLE_CYC+1 cycles.
REQ-020 Latency for a single-bit change written at edge T:
- eni changes at edge T+2;
- done is high in the cycle after edge T+2+SETTLE_CYC.
REQ-021 A TARGET write equal to the current eni while in IDLE SHALL cause no FSM activity and no done pulse.
REQ-022 A TARGET write and a SETTLE exit on the same edge SHALL use the pre-write tgt for that exit decision; the new tgt is evaluated from the next cycle on.

Reset
REQ-023 resetb low SHALL asynchronously set:
- eni=0, tgt=0, lock=0, counter=0, FSM=IDLE, busy=0, done=0.
REQ-024 Reset asserted mid-sequence SHALL abandon the sequence; the sequencer does not resume after reset release.

Configuration
REQ-025 Macro P12_ENI_LOCK_EN, when defined, SHALL compile in a CTRL lock bit:
- a write with addr=1 and wdata[0]=1 sets lock;
- lock is sticky until reset;
- while lock=1, TARGET writes are ignored;
- a sequence already in progress completes.
REQ-026 Without P12_ENI_LOCK_EN:
- CTRL writes SHALL be ignored;
- lock SHALL read 0;
- no lock logic SHALL be present.

Verification
REQ-027 Reset, then write TARGET=3'b001 at edge T (SETTLE_CYC=4) -> eni=001 at T+2; busy high T+1..T+6; done one cycle after T+6.
REQ-028 From eni=000, write TARGET=3'b111 -> eni steps 001, 011, 111 at 5-cycle spacing; a single done pulse at the end.
REQ-029 From eni=111, write 000; during the first SETTLE write 110 -> eni goes 110 after the first step, then IDLE; done pulses once.
REQ-030 Assert resetb low mid-SETTLE at eni=011 -> eni, tgt, busy and done go to 0 immediately; after release the block stays IDLE.
REQ-031 With P12_ENI_LOCK_EN: write CTRL=1, then TARGET=3'b101 -> tgt reads 0 and eni stays 000; without the macro the same stimulus -> eni reaches 101 and CTRL reads lock=0.
REQ-032 Write TARGET equal to the current eni -> busy stays 0 and no done pulse occurs.
